// File: rtl/fpga_spi_byte_slave.sv
// fpga_spi_byte_slave: SPI mode-0 byte slave clocked from DCLK.
// Oversamples SCK/SS_N/MOSI through synchronizers, assembles MSB-first bytes,
// strobes each complete byte and returns byte_in to the host on MISO.
// Optional feature macro: FSPI_MISO_HIZ_EN (MISO floats while no frame is active).
`timescale 1ns/1ps

module fpga_spi_byte_slave #(
  parameter int unsigned STRB_CYCLES = 2,
  parameter int unsigned SYNC_STAGES = 3
) (
  input  logic        DCLK,
  input  logic        rst,
  input  logic        SPI_SCK,
  input  logic        SPI_SS_N,
  input  logic        SPI_MOSI,
  output logic        SPI_MISO,
  output logic [7:0]  byte_out,
  output logic        byte_strb,
  input  logic [7:0]  byte_in,
  output logic        frame_active,
  output logic [15:0] byte_cnt,
  output logic        frame_err
);

  localparam int unsigned LAST = SYNC_STAGES - 1;
  localparam int unsigned PREV = SYNC_STAGES - 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_ss_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [2:0]             r_flush_cnt;
  logic                   r_armed;
  logic [3:0]             r_bit_cnt;
  logic [7:0]             r_rx_shift;
  logic [7:0]             r_tx_shift;
  logic [7:0]             r_byte_out;
  logic                   r_byte_strb;
  logic [2:0]             r_strb_cnt;
  logic                   r_frame_active;
  logic [15:0]            r_byte_cnt;
  logic                   r_frame_err;

  logic w_sck;
  logic w_sck_d;
  logic w_ss;
  logic w_ss_d;
  logic w_mosi;
  logic w_sck_rise;
  logic w_sck_fall;
  logic w_ss_rise;
  logic w_ss_fall;
  logic w_flush_done;
  logic w_complete;

  // Input synchronizers; SCK idles low and SS_N idles high out of reset
  always_ff @(posedge DCLK or posedge rst) begin
    if (rst) begin
      r_sck_sync  <= '0;
      r_ss_sync   <= '1;
      r_mosi_sync <= '0;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], SPI_SCK};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], SPI_SS_N};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], SPI_MOSI};
    end
  end

  assign w_sck      = r_sck_sync[PREV];
  assign w_sck_d    = r_sck_sync[LAST];
  assign w_ss       = r_ss_sync[PREV];
  assign w_ss_d     = r_ss_sync[LAST];
  assign w_mosi     = r_mosi_sync[PREV];
  assign w_sck_rise = w_sck & ~w_sck_d;
  assign w_sck_fall = ~w_sck & w_sck_d;
  assign w_ss_rise  = w_ss & ~w_ss_d;
  assign w_ss_fall  = ~w_ss & w_ss_d;

  assign w_flush_done = (r_flush_cnt == 3'(SYNC_STAGES));
  assign w_complete   = (r_state == SHIFT) && w_sck_rise && (r_bit_cnt == 4'd7);

  // Arm frame detection only after SS_N has been seen high post-reset, so a
  // frame interrupted by reset is not mistaken for a new one
  always_ff @(posedge DCLK or posedge rst) begin
    if (rst) begin
      r_flush_cnt <= 3'd0;
      r_armed     <= 1'b0;
    end else begin
      if (!w_flush_done) begin
        r_flush_cnt <= r_flush_cnt + 3'd1;
      end
      if (w_flush_done && w_ss) begin
        r_armed <= 1'b1;
      end
    end
  end

  // Strobe width counter; runs to completion regardless of frame state
  always_ff @(posedge DCLK or posedge rst) begin
    if (rst) begin
      r_byte_strb <= 1'b0;
      r_strb_cnt  <= 3'd0;
    end else if (w_complete) begin
      r_byte_strb <= 1'b1;
      r_strb_cnt  <= 3'(STRB_CYCLES - 1);
    end else if (r_strb_cnt != 3'd0) begin
      r_strb_cnt  <= r_strb_cnt - 3'd1;
    end else begin
      r_byte_strb <= 1'b0;
    end
  end

  // Frame/byte FSM with its datapath registers
  always_ff @(posedge DCLK or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_bit_cnt      <= 4'd0;
      r_rx_shift     <= 8'h00;
      r_tx_shift     <= 8'h00;
      r_byte_out     <= 8'h00;
      r_frame_active <= 1'b0;
      r_byte_cnt     <= 16'h0000;
      r_frame_err    <= 1'b0;
    end else begin
      r_frame_err    <= 1'b0;
      r_frame_active <= r_armed & ~w_ss;

      if (w_complete) begin
        r_byte_out <= {r_rx_shift[6:0], w_mosi};
        if (r_byte_cnt != 16'hFFFF) begin
          r_byte_cnt <= r_byte_cnt + 16'd1;
        end
      end

      if (w_ss_rise) begin
        // A byte completing in this same cycle is not a partial byte
        if ((r_state == SHIFT) && (r_bit_cnt != 4'd0) && (r_bit_cnt != 4'd8) && !w_complete) begin
          r_frame_err <= 1'b1;
        end
        r_state   <= IDLE;
        r_bit_cnt <= 4'd0;
      end else begin
        case (r_state)
          IDLE: begin
            r_tx_shift <= byte_in;
            if (w_ss_fall && r_armed) begin
              r_state    <= LOAD;
              r_bit_cnt  <= 4'd0;
              r_byte_cnt <= 16'h0000;
            end
          end
          LOAD: begin
            r_bit_cnt  <= 4'd0;
            r_tx_shift <= byte_in;
            if (w_sck_rise) begin
              r_rx_shift <= {r_rx_shift[6:0], w_mosi};
              r_bit_cnt  <= 4'd1;
              r_state    <= SHIFT;
            end
          end
          SHIFT: begin
            if (w_sck_fall) begin
              if (r_bit_cnt == 4'd8) begin
                r_state   <= LOAD;
                r_bit_cnt <= 4'd0;
              end else begin
                r_tx_shift <= {r_tx_shift[6:0], 1'b0};
              end
            end
            if (w_sck_rise && (r_bit_cnt != 4'd8)) begin
              r_rx_shift <= {r_rx_shift[6:0], w_mosi};
              r_bit_cnt  <= r_bit_cnt + 4'd1;
            end
          end
          default: begin
            r_state   <= IDLE;
            r_bit_cnt <= 4'd0;
          end
        endcase
      end
    end
  end

  assign byte_out     = r_byte_out;
  assign byte_strb    = r_byte_strb;
  assign frame_active = r_frame_active;
  assign byte_cnt     = r_byte_cnt;
  assign frame_err    = r_frame_err;

  // MISO presents the transmit MSB only while a frame is active
`ifdef FSPI_MISO_HIZ_EN
  assign SPI_MISO = r_frame_active ? r_tx_shift[7] : 1'bz;
`else
  assign SPI_MISO = r_frame_active ? r_tx_shift[7] : 1'b0;
`endif

endmodule

// File: doc/fpga_spi_byte_slave.md
FPGA_SPI_BYTE_SLAVE -- requirements
Module: fpga_spi_byte_slave

Interface
REQ-001 The block SHALL have parameter STRB_CYCLES, default 2, giving the byte_strb high width in DCLK cycles (legal range 1..7).
REQ-002 The block SHALL have parameter SYNC_STAGES, default 3, giving the flop depth of the SCK/SS_N/MOSI synchronizers (legal range 2..4).
REQ-003 Port DCLK, input, 1 bit: system clock (48-64 MHz); all logic is on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 Port SPI_SCK, input, 1 bit: host SPI clock, mode 0, at most DCLK/8.
REQ-006 Port SPI_SS_N, input, 1 bit: host chip select, active-low.
REQ-007 Port SPI_MOSI, input, 1 bit: host data in, MSB first.
REQ-008 Port SPI_MISO, output, 1 bit: data to host, MSB first.
REQ-009 Port byte_out, output, 8 bits: last complete received byte, feeds the pulser from_spi.
REQ-010 Port byte_strb, output, 1 bit: high for STRB_CYCLES cycles per received byte, feeds the pulser spi_strb.
REQ-011 Port byte_in, input, 8 bits: next byte to return to the host, driven by the pulser to_spi.
REQ-012 Port frame_active, output, 1 bit: synchronized SS_N is low.
REQ-013 Port byte_cnt, output, 16 bits: complete bytes received in the current frame, saturating at 0xFFFF.
REQ-014 Port frame_err, output, 1 bit: one-cycle pulse when a frame ends mid-byte.

Function
REQ-015 SCK, SS_N and MOSI SHALL each pass through a SYNC_STAGES-deep synchronizer; edges are detected from the last two stages.
REQ-016 The FSM SHALL have states IDLE, LOAD and SHIFT.
REQ-017 IDLE -> LOAD on a synchronized SS_N fall; any state -> IDLE on a synchronized SS_N rise.
REQ-018 LOAD: bit_cnt=0; each cycle tx_shift<=byte_in (tracks live); on a synced SCK rise, sample MOSI, bit_cnt=1 -> SHIFT.
REQ-019 SHIFT: on a synced SCK fall, tx_shift shifts left by one; on a synced SCK rise, sample MOSI into rx_shift LSB and increment bit_cnt.
REQ-020 On the 8th rise: byte_out<={rx_shift[6:0],MOSI} on the next DCLK cycle, byte_strb asserts in that same cycle, byte_cnt increments (saturating), and the state returns to LOAD after the following SCK fall.
REQ-021 byte_out SHALL be stable from strobe assertion until the next strobe.
REQ-022 SPI_MISO SHALL equal tx_shift[7] while frame_active=1.
REQ-023 The host SHALL leave at least 12 DCLK cycles between the 8th SCK fall and the next SCK rise; the byte_in value present at that rise is returned in full.
REQ-024 An SS_N rise with bit_cnt!=0 SHALL: discard the partial byte, generate no strobe, pulse frame_err once, and go to IDLE.
REQ-025 byte_cnt SHALL clear on an SS_N fall and hold its value after the frame ends.
REQ-026 If SS_N rises in the same cycle as the 8th SCK rise, the byte SHALL complete and strobe, and frame_err SHALL stay low.
REQ-027 A strobe in progress SHALL complete its full width even if SS_N rises.

Reset
REQ-028 While rst=1, the block SHALL hold: state=IDLE, byte_out=0x00, byte_strb=0, SPI_MISO=0, frame_active=0, byte_cnt=0, frame_err=0, bit_cnt=0, and all synchronizers at their idle values (SCK=0, SS_N=1).
REQ-029 Reset asserted mid-frame SHALL abort the frame without a strobe or frame_err; after release the block waits for a fresh SS_N fall.

Configuration
REQ-030 With FSPI_MISO_HIZ_EN defined, SPI_MISO SHALL be high-Z while frame_active=0; without it, SPI_MISO SHALL drive 0 while frame_active=0.

Verification
REQ-031 Frame with bytes 0xA5, 0x3C at SCK=DCLK/8 -> two strobes of 2 cycles; byte_out=0xA5 then 0x3C; byte_cnt=2; frame_err=0.
REQ-032 byte_in=0x5A before byte 1, changed to 0xC3 during the inter-byte gap -> host reads 0x5A then 0xC3 on MISO.
REQ-033 SS_N rises after 4 SCK rises -> no strobe; one frame_err pulse; the next frame's byte 0x81 is received correctly.
REQ-034 rst asserted after 5 bits -> all outputs return to reset values immediately; a new frame sending 0x7E yields byte_out=0x7E.
REQ-035 SS_N rise coincident with the 8th SCK rise of 0xFF -> strobe occurs, byte_out=0xFF, frame_err=0.
REQ-036 Idle bus, with and without FSPI_MISO_HIZ_EN -> SPI_MISO is z or 0 respectively.
